// File: rtl/layer_compositor.sv
// layer_compositor
// Priority compositor for the VGA pixel path. Every pixel cycle it selects,
// among NUM_LAYERS drawing requests, the layer with the smallest z-index
// (lower index wins ties) and emits its colour, or the background colour when
// no layer draws. Z-indexes and enables live in a shadow register file that is
// copied to the active set on frame_start. Fixed latency LAT = 1 + IDX_W,
// one pixel per cycle, no backpressure.
//
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   in_valid          pixel inputs valid this cycle
//   layer_rgb         layer i colour at [i*COLOR_W +: COLOR_W]
//   layer_dr          per-layer drawing request
//   background_rgb    colour used when no layer wins (travels with its pixel)
//   frame_start       commits shadow config to active config
//   cfg_we/cfg_layer/cfg_z/cfg_en  shadow config write port
//   out_valid         outputs valid (data outputs hold during bubbles)
//   rgb_out           composited colour
//   out_hit           a layer won (0 = background)
//   out_layer         winning layer index (0 when out_hit = 0)
module layer_compositor #(
    parameter int                 NUM_LAYERS        = 8,
    parameter int                 COLOR_W           = 8,
    parameter int                 Z_W               = 4,
    parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = COLOR_W'(8'hFF),
    localparam int                IDX_W             = $clog2(NUM_LAYERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]         layer_dr,
    input  logic [COLOR_W-1:0]            background_rgb,
    input  logic                          frame_start,
    input  logic                          cfg_we,
    input  logic [IDX_W-1:0]              cfg_layer,
    input  logic [Z_W-1:0]                cfg_z,
    input  logic                          cfg_en,
    output logic                          out_valid,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic                          out_hit,
    output logic [IDX_W-1:0]              out_layer
);

    typedef struct packed {
        logic               v;
        logic [Z_W-1:0]     z;
        logic [IDX_W-1:0]   idx;
        logic [COLOR_W-1:0] rgb;
    } cand_t;

    // Number of live elements at reduction level l.
    function automatic int lvl_cnt(input int l);
        return (NUM_LAYERS + (1 << l) - 1) >> l;
    endfunction

    // a is always the lower-index side, so it wins ties on z.
    function automatic cand_t pick(input cand_t a, input cand_t b);
        if (a.v && (!b.v || a.z <= b.z))
            return a;
        return b;
    endfunction

    logic [Z_W-1:0]        shadow_z_q [NUM_LAYERS];
    logic [Z_W-1:0]        active_z_q [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] shadow_en_q;
    logic [NUM_LAYERS-1:0] active_en_q;
    logic [NUM_LAYERS-1:0] cfg_hit_d;

    cand_t                 lvl_q [IDX_W][NUM_LAYERS];
    logic [COLOR_W-1:0]    bg_q  [IDX_W];
    logic [IDX_W-1:0]      vld_q;
    cand_t                 win_d;

    // Decoding against each in-range index drops writes to nonexistent layers.
    always_comb begin
        cfg_hit_d = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            cfg_hit_d[i] = cfg_we && (cfg_layer == IDX_W'(i));
    end

    // Shadow/active config. A write coinciding with frame_start is forwarded
    // straight into the active entry so it lands in this commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow_z_q[i] <= Z_W'(i);
                active_z_q[i] <= Z_W'(i);
            end
            shadow_en_q <= '1;
            active_en_q <= '1;
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (cfg_hit_d[i]) begin
                    shadow_z_q[i]  <= cfg_z;
                    shadow_en_q[i] <= cfg_en;
                end
                if (frame_start) begin
                    active_z_q[i]  <= cfg_hit_d[i] ? cfg_z  : shadow_z_q[i];
                    active_en_q[i] <= cfg_hit_d[i] ? cfg_en : shadow_en_q[i];
                end
            end
        end
    end

    // Control path: valid shift and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
            rgb_out   <= '0;
            out_hit   <= 1'b0;
            out_layer <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int l = 1; l < IDX_W; l++)
                vld_q[l] <= vld_q[l-1];
            out_valid <= vld_q[IDX_W-1];
            // Final stage: last compare plus background substitution.
            if (vld_q[IDX_W-1]) begin
                out_hit   <= win_d.v;
                rgb_out   <= win_d.v ? win_d.rgb : bg_q[IDX_W-1];
                out_layer <= win_d.v ? win_d.idx : '0;
            end
        end
    end

    // The last internal level always holds exactly two elements.
    always_comb win_d = pick(lvl_q[IDX_W-1][0], lvl_q[IDX_W-1][1]);

    always_ff @(posedge clk) begin
        // Stage 0: input register, candidate qualification with active config.
        if (in_valid) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                lvl_q[0][i] <= '{
                    v:   layer_dr[i] && active_en_q[i] &&
                         (layer_rgb[i*COLOR_W +: COLOR_W] != TRANSPARENT_COLOR),
                    z:   active_z_q[i],
                    idx: IDX_W'(i),
                    rgb: layer_rgb[i*COLOR_W +: COLOR_W]
                };
            end
            bg_q[0] <= background_rgb;
        end
        // Stages 1..IDX_W-1: pairwise reduction; an unpaired element is
        // compared against an invalid entry, which passes it through.
        for (int l = 1; l < IDX_W; l++) begin
            if (vld_q[l-1]) begin
                bg_q[l] <= bg_q[l-1];
                for (int j = 0; j < NUM_LAYERS; j++) begin
                    if (j < lvl_cnt(l))
                        lvl_q[l][j] <= pick(lvl_q[l-1][(2*j) % NUM_LAYERS],
                                            (2*j+1 < lvl_cnt(l-1)) ?
                                                lvl_q[l-1][(2*j+1) % NUM_LAYERS] : '0);
                    else
                        lvl_q[l][j] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;
    localparam int N   = 8;
    localparam int C   = 8;
    localparam int ZW  = 4;
    localparam int IW  = 3;
    localparam int LAT = 4;
    localparam logic [N*C-1:0] BASE = 64'h7060_5040_3020_1000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic [N*C-1:0] layer_rgb = '0;
    logic [N-1:0]   layer_dr = '0;
    logic [C-1:0]   background_rgb = '0;
    logic           frame_start = 1'b0;
    logic           cfg_we = 1'b0;
    logic [IW-1:0]  cfg_layer = '0;
    logic [ZW-1:0]  cfg_z = '0;
    logic           cfg_en = 1'b0;
    logic           out_valid;
    logic [C-1:0]   rgb_out;
    logic           out_hit;
    logic [IW-1:0]  out_layer;

    layer_compositor #(.NUM_LAYERS(N), .COLOR_W(C), .Z_W(ZW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .layer_rgb(layer_rgb),
        .layer_dr(layer_dr), .background_rgb(background_rgb),
        .frame_start(frame_start), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
        .cfg_z(cfg_z), .cfg_en(cfg_en), .out_valid(out_valid), .rgb_out(rgb_out),
        .out_hit(out_hit), .out_layer(out_layer)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [C-1:0]  rgb;
        logic          hit;
        logic [IW-1:0] layer;
    } exp_t;

    typedef struct {
        logic [N-1:0]   dr;
        logic [N*C-1:0] rgbs;
        logic [C-1:0]   bg;
        exp_t           e;
    } vec_t;

    int            total = 0;
    int            bad = 0;
    exp_t          q[$];
    exp_t          last = '0;
    exp_t          mon_e;
    logic [ZW-1:0] m_z [N];
    logic [ZW-1:0] s_z [N];
    logic [N-1:0]  m_en = '1;
    logic [N-1:0]  s_en = '1;
    logic [LAT-1:0] vhist = '0;
    vec_t          tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference: linear scan keeping the strictly smallest z.
    function automatic exp_t model_px();
        exp_t          r;
        bit            found = 0;
        logic [ZW-1:0] bz = '0;
        int            bi = 0;
        for (int i = 0; i < N; i++) begin
            if (layer_dr[i] && m_en[i] && layer_rgb[i*C +: C] != 8'hFF) begin
                if (!found || m_z[i] < bz) begin
                    found = 1;
                    bz = m_z[i];
                    bi = i;
                end
            end
        end
        r.hit = found;
        r.rgb = found ? layer_rgb[bi*C +: C] : background_rgb;
        r.layer = found ? IW'(bi) : '0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) vhist <= '0;
        else       vhist <= {vhist[LAT-2:0], in_valid};
    end

    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(vhist[LAT-1]));
        if (out_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output got=%0h exp=none", rgb_out);
            end else begin
                mon_e = q.pop_front();
                check("rgb_out", 32'(rgb_out), 32'(mon_e.rgb));
                check("out_hit", 32'(out_hit), 32'(mon_e.hit));
                check("out_layer", 32'(out_layer), 32'(mon_e.layer));
                last = mon_e;
            end
        end else begin
            check("hold_rgb", 32'(rgb_out), 32'(last.rgb));
            check("hold_hit", 32'(out_hit), 32'(last.hit));
            check("hold_layer", 32'(out_layer), 32'(last.layer));
        end
    end

    // One clock: optionally score the current pixel with the model, advance
    // the model config the same way the clock edge will, then step.
    task automatic cycle(input bit use_model);
        if (in_valid && !reset && use_model) q.push_back(model_px());
        if (reset) begin
            q.delete();
            for (int i = 0; i < N; i++) begin
                m_z[i] = ZW'(i);
                s_z[i] = ZW'(i);
            end
            m_en = '1;
            s_en = '1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (frame_start) begin
                    if (cfg_we && cfg_layer == IW'(i)) begin
                        m_z[i] = cfg_z;
                        m_en[i] = cfg_en;
                    end else begin
                        m_z[i] = s_z[i];
                        m_en[i] = s_en[i];
                    end
                end
                if (cfg_we && cfg_layer == IW'(i)) begin
                    s_z[i] = cfg_z;
                    s_en[i] = cfg_en;
                end
            end
        end
        @(posedge clk);
        #1;
        if (reset) last = '0;
    endtask

    task automatic px(input logic [N-1:0] dr, input logic [N*C-1:0] rgbs, input logic [C-1:0] bg);
        in_valid = 1'b1;
        layer_dr = dr;
        layer_rgb = rgbs;
        background_rgb = bg;
    endtask

    task automatic push_exp(input logic [C-1:0] rgb, input logic hit, input logic [IW-1:0] layer);
        exp_t e;
        e.rgb = rgb;
        e.hit = hit;
        e.layer = layer;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        cfg_we = 1'b0;
        frame_start = 1'b0;
        repeat (n) cycle(0);
    endtask

    initial begin
        tbl[0] = '{dr: 8'h2C, rgbs: BASE, bg: 8'h33, e: '{rgb: 8'h20, hit: 1'b1, layer: 3'd2}};
        tbl[1] = '{dr: 8'h00, rgbs: BASE, bg: 8'h33, e: '{rgb: 8'h33, hit: 1'b0, layer: 3'd0}};
        tbl[2] = '{dr: 8'h24, rgbs: 64'h7060_5040_30FF_1000, bg: 8'h33, e: '{rgb: 8'h50, hit: 1'b1, layer: 3'd5}};
        tbl[3] = '{dr: 8'hFF, rgbs: BASE, bg: 8'h12, e: '{rgb: 8'h00, hit: 1'b1, layer: 3'd0}};
        tbl[4] = '{dr: 8'h80, rgbs: BASE, bg: 8'h12, e: '{rgb: 8'h70, hit: 1'b1, layer: 3'd7}};
        tbl[5] = '{dr: 8'h01, rgbs: 64'h7060_5040_3020_10FF, bg: 8'hA5, e: '{rgb: 8'hA5, hit: 1'b0, layer: 3'd0}};
        tbl[6] = '{dr: 8'hC0, rgbs: BASE, bg: 8'hA5, e: '{rgb: 8'h60, hit: 1'b1, layer: 3'd6}};
        tbl[7] = '{dr: 8'hFF, rgbs: '1, bg: 8'h01, e: '{rgb: 8'h01, hit: 1'b0, layer: 3'd0}};

        reset = 1'b1;
        cycle(0);
        cycle(0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rgb_out", 32'(rgb_out), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_out_layer", 32'(out_layer), 32'd0);
        reset = 1'b0;
        cycle(0);

        // Back-to-back table vectors with default config.
        for (int k = 0; k < 8; k++) begin
            px(tbl[k].dr, tbl[k].rgbs, tbl[k].bg);
            q.push_back(tbl[k].e);
            cycle(0);
        end
        idle(LAT + 1);

        // Shadow write without commit: layer 2 still wins, both in the write
        // cycle and after it.
        cfg_we = 1'b1; cfg_layer = 3'd5; cfg_z = 4'd0; cfg_en = 1'b1;
        px(8'h24, BASE, 8'h00); push_exp(8'h20, 1'b1, 3'd2);
        cycle(0);
        cfg_we = 1'b0;
        push_exp(8'h20, 1'b1, 3'd2);
        cycle(0);
        // Commit, then the same pixel picks layer 5.
        in_valid = 1'b0; frame_start = 1'b1;
        cycle(0);
        frame_start = 1'b0;
        px(8'h24, BASE, 8'h00); push_exp(8'h50, 1'b1, 3'd5);
        cycle(0);
        // Write z[2]=0 with commit; pixel in that cycle uses old config.
        cfg_we = 1'b1; cfg_layer = 3'd2; cfg_z = 4'd0; cfg_en = 1'b1; frame_start = 1'b1;
        push_exp(8'h50, 1'b1, 3'd5);
        cycle(0);
        cfg_we = 1'b0; frame_start = 1'b0;
        push_exp(8'h20, 1'b1, 3'd2);
        cycle(0);
        // Disable layer 3 with same-cycle commit.
        cfg_we = 1'b1; cfg_layer = 3'd3; cfg_z = 4'd3; cfg_en = 1'b0; frame_start = 1'b1;
        px(8'h08, BASE, 8'h44); push_exp(8'h30, 1'b1, 3'd3);
        cycle(0);
        cfg_we = 1'b0; frame_start = 1'b0;
        push_exp(8'h44, 1'b0, 3'd0);
        cycle(0);
        // Back-to-back frame_start pulses, each with its own write.
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_layer = 3'd7; cfg_z = 4'd0; cfg_en = 1'b1; frame_start = 1'b1;
        cycle(0);
        cfg_en = 1'b0;
        px(8'h88, BASE, 8'h55); push_exp(8'h70, 1'b1, 3'd7);
        cycle(0);
        cfg_we = 1'b0; frame_start = 1'b0;
        push_exp(8'h55, 1'b0, 3'd0);
        cycle(0);
        idle(LAT + 1);

        // Random streaming with bubbles and config traffic.
        for (int k = 0; k < 100; k++) begin
            if ($urandom_range(3) == 0) begin
                in_valid = 1'b0;
                cycle(1);
            end
            in_valid = 1'b1;
            layer_dr = N'($urandom);
            for (int i = 0; i < N; i++)
                layer_rgb[i*C +: C] = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
            background_rgb = 8'($urandom);
            cfg_we = ($urandom_range(3) == 0);
            cfg_layer = IW'($urandom);
            cfg_z = ZW'($urandom);
            cfg_en = ($urandom_range(4) != 0);
            frame_start = ($urandom_range(7) == 0);
            cycle(1);
            cfg_we = 1'b0;
            frame_start = 1'b0;
        end
        idle(LAT + 1);

        // Reset with the pipe full; identity z restored afterwards.
        for (int k = 0; k < 3; k++) begin
            px(8'hFF, BASE, 8'h99);
            cycle(1);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        cycle(0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_rgb_out", 32'(rgb_out), 32'd0);
        check("midrst_out_hit", 32'(out_hit), 32'd0);
        check("midrst_out_layer", 32'(out_layer), 32'd0);
        reset = 1'b0;
        px(8'h24, BASE, 8'h11); push_exp(8'h20, 1'b1, 3'd2);
        cycle(0);
        px(8'hA0, BASE, 8'h11); push_exp(8'h50, 1'b1, 3'd5);
        cycle(0);
        idle(LAT + 2);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Pipelined, parametrised priority compositor for the VGA graphics path. Each pixel cycle it picks, among up to NUM_LAYERS drawing requests, the layer with the smallest z-index and outputs its colour, or the background colour if no layer draws. Z-indexes and layer enables are runtime-programmable through a shadow register file that commits only at frame boundaries. It sits between the per-object drawing units and the VGA output stage, with fixed latency and no backpressure.

## Interface
- NUM_LAYERS, 8, number of layer inputs (2..32)
- COLOR_W, 8, colour width per pixel
- Z_W, 4, z-index width
- TRANSPARENT_COLOR, 8'hFF, layer colour treated as "not drawing" (COLOR_W bits)
- IDX_W, $clog2(NUM_LAYERS), layer index width (derived; do not override)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  pixel inputs valid this cycle
- layer_rgb  in  NUM_LAYERS*COLOR_W  layer i colour at bits [i*COLOR_W +: COLOR_W]
- layer_dr  in  NUM_LAYERS  layer i drawing request
- background_rgb  in  COLOR_W  colour used when no layer wins
- frame_start  in  1  one-cycle pulse; commits shadow config to active config
- cfg_we  in  1  shadow config write strobe
- cfg_layer  in  IDX_W  layer index to write
- cfg_z  in  Z_W  new z-index
- cfg_en  in  1  new enable for the layer
- out_valid  out  1  rgb_out/out_hit/out_layer valid
- rgb_out  out  COLOR_W  composited colour
- out_hit  out  1  a layer won (0 = background)
- out_layer  out  IDX_W  winning layer index (0 when out_hit=0)

## Operation
- Layer i is a candidate iff layer_dr[i]=1, active_en[i]=1, and layer_rgb[i] != TRANSPARENT_COLOR.
- Winner: the candidate with the smallest active_z. On equal z, the lower index wins. No candidate -> rgb_out=background_rgb, out_hit=0, out_layer=0.
- Z comparison is unsigned on Z_W bits.
- Implementation: input register stage, then a binary reduction tree of registered (valid, z, idx, rgb) pairwise compare stages. There are IDX_W levels. For odd counts at a level, the unpaired element passes through a register. The background substitution happens at the final stage. background_rgb is carried through the pipe with its pixel.
- Config: shadow_z[NUM_LAYERS] and shadow_en[NUM_LAYERS] registers.
  - cfg_we writes shadow_z[cfg_layer]=cfg_z and shadow_en[cfg_layer]=cfg_en at the clock edge.
  - cfg_layer >= NUM_LAYERS is ignored.
- Commit: on the frame_start edge, active <= shadow. If cfg_we is asserted in the same cycle, the written value is included in the commit (the active entry takes cfg_z/cfg_en directly).
- Active config is sampled in the input-stage cycle. A pixel presented in the same cycle as frame_start uses the pre-commit config. Pixels from the next cycle on use the new config.
- in_valid=0 cycles propagate as bubbles: out_valid=0, and the data outputs hold their last values.

## Timing
- Latency LAT = 1 + IDX_W cycles from in_valid to out_valid (LAT=4 for NUM_LAYERS=8).
- Throughput is one pixel per cycle. Output order equals input order.
- Reset behaviour:
  - All pipeline valids clear. out_valid=0, rgb_out=0, out_hit=0, out_layer=0.
  - shadow_z[i] and active_z[i] = i truncated to Z_W. shadow_en and active_en = all 1.
- Reset mid-frame drops all in-flight pixels. The first post-reset output appears LAT cycles after the first in_valid.
- A config write without frame_start never changes output for pixels already in flight or for later pixels until the next frame_start.
- Back-to-back frame_start pulses each commit the current shadow state.

## Test plan
- Defaults, NUM_LAYERS=8: layer_dr=8'b0010_1100, colours 8'h10*i -> after 4 cycles rgb_out=8'h20, out_layer=2, out_hit=1. With layer_dr=0 -> rgb_out=background_rgb, out_hit=0.
- Transparency: layers 2 and 5 draw, layer 2 colour=8'hFF -> rgb_out=8'h50, out_layer=5.
- Reprogramming:
  - Write z[5]=0, then pixel with layers 2 and 5 drawing -> layer 2 still wins, since no commit has happened.
  - After frame_start, the same pixel -> layer 5 wins.
  - Write z[2]=0 and pulse frame_start -> tie on z=0 -> layer 2 wins (lower index).
- Disable and same-cycle commit: cfg_we with cfg_layer=3, cfg_en=0, together with frame_start. A pixel in that cycle with only layer 3 drawing -> layer 3 wins. The same pixel one cycle later -> background.
- Streaming: 100 consecutive random pixels with random bubbles, checked against a reference model -> outputs match in order at fixed LAT, and out_valid mirrors in_valid delayed by LAT.
- Reset mid-stream: assert reset with pipe full -> out_valid=0 the next cycle and all outputs 0. Active z restored to the identity mapping, verified by the first post-reset pixel.
